// File: rtl/tx_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tx_arb_pkg
// Description : Shared types and constants for the TX frame arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package tx_arb_pkg;

    // Arbiter FSM encoding; ABORT/DRAIN only reachable with TX_ARB_TIMEOUT_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS  = 2'd1,
        ABORT = 2'd2,
        DRAIN = 2'd3
    } state_t;

    // tuser bit that tells the downstream frame FIFO to drop the frame
    localparam int BAD_FRAME_BIT = 0;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin pick. Searches upward (mod PORTS)
//               starting one above the pointer and returns a one-hot grant
//               plus the index of the selected requester.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int PORTS = 4
) (
    input  logic [PORTS-1:0]         i_req,
    input  logic [$clog2(PORTS)-1:0] i_ptr,
    output logic [PORTS-1:0]         o_gnt,
    output logic [$clog2(PORTS)-1:0] o_idx
);

    localparam int c_IDX_W = $clog2(PORTS);

    int   w_cand;
    logic w_found;

    // First requester after the pointer wins; the pointer itself is checked last
    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_cand  = 0;
        for (int i = 1; i <= PORTS; i++) begin
            w_cand = int'(i_ptr) + i;
            if (w_cand >= PORTS) begin
                w_cand = w_cand - PORTS;
            end
            if (!w_found && i_req[w_cand]) begin
                w_found       = 1'b1;
                o_gnt[w_cand] = 1'b1;
                o_idx         = c_IDX_W'(w_cand);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/tx_frame_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tx_frame_arbiter
// Description : Frame-granular round-robin arbiter sharing one 8-bit
//               AXI-stream TX path among PORTS sources. A port keeps the
//               grant from its first beat through its tlast handshake.
//               Optional feature macro TX_ARB_TIMEOUT_EN builds a stall
//               watchdog that closes a stalled frame with a bad-frame beat
//               and then sinks the rest of the source frame.
// Revision    : 1.0 - initial release
// ============================================================================
module tx_frame_arbiter
    import tx_arb_pkg::*;
#(
    parameter int PORTS      = 4,
    parameter int USER_WIDTH = 1,
    parameter int TIMEOUT    = 1024
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [PORTS*8-1:0]          s_axis_tdata,
    input  logic [PORTS-1:0]            s_axis_tvalid,
    output logic [PORTS-1:0]            s_axis_tready,
    input  logic [PORTS-1:0]            s_axis_tlast,
    input  logic [PORTS*USER_WIDTH-1:0] s_axis_tuser,
    output logic [7:0]                  m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic                        m_axis_tlast,
    output logic [USER_WIDTH-1:0]       m_axis_tuser,
    output logic [PORTS-1:0]            grant,
    output logic                        busy,
    output logic                        abort_pulse
);

    localparam int c_IDX_W = $clog2(PORTS);

    state_t               r_state;
    logic [PORTS-1:0]     r_grant;
    logic [c_IDX_W-1:0]   r_ptr;     // last granted port, also the current owner

    logic [PORTS-1:0]     w_arb_gnt;
    logic [c_IDX_W-1:0]   w_arb_idx;
    logic                 w_src_valid;
    logic                 w_src_last;
    logic                 w_hs;

    assign w_src_valid = s_axis_tvalid[r_ptr];
    assign w_src_last  = s_axis_tlast[r_ptr];
    assign w_hs        = m_axis_tvalid & m_axis_tready;
    assign grant       = r_grant;
    assign busy        = (r_state != IDLE);

    rr_arbiter #(
        .PORTS (PORTS)
    ) u_rr (
        .i_req (s_axis_tvalid),
        .i_ptr (r_ptr),
        .o_gnt (w_arb_gnt),
        .o_idx (w_arb_idx)
    );

`ifdef TX_ARB_TIMEOUT_EN
    localparam logic [15:0] c_TIMEOUT_LAST = 16'(TIMEOUT - 1);

    logic [15:0] r_stall_cnt;
    logic        w_stall_expire;

    // Expiry is decided here and takes effect on the next edge, so a source
    // that wakes up on the ABORT cycle is still aborted
    assign w_stall_expire = (r_state == PASS) && !w_src_valid &&
                            (r_stall_cnt == c_TIMEOUT_LAST);
    assign abort_pulse    = (r_state == ABORT) && m_axis_tready;

    // Count owner-idle cycles; downstream backpressure is not a stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (r_state == IDLE || w_hs) begin
            r_stall_cnt <= '0;
        end else if (r_state == PASS && !w_src_valid && !w_stall_expire) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end
`else
    assign abort_pulse = 1'b0;
`endif

    // Frame-level FSM: arbitrate in IDLE, hold the owner until its frame ends
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_ptr   <= c_IDX_W'(PORTS - 1);
        end else begin
            case (r_state)
                IDLE: begin
                    if (|s_axis_tvalid) begin
                        r_grant <= w_arb_gnt;
                        r_ptr   <= w_arb_idx;
                        r_state <= PASS;
                    end
                end
                PASS: begin
                    if (w_hs && m_axis_tlast) begin
                        r_state <= IDLE;
                        r_grant <= '0;
                    end
`ifdef TX_ARB_TIMEOUT_EN
                    else if (w_stall_expire) begin
                        r_state <= ABORT;
                    end
`endif
                end
`ifdef TX_ARB_TIMEOUT_EN
                ABORT: begin
                    if (m_axis_tready) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_src_valid && w_src_last) begin
                        r_state <= IDLE;
                        r_grant <= '0;
                    end
                end
`endif
                default: begin
                    r_state <= IDLE;
                    r_grant <= '0;
                end
            endcase
        end
    end

    // Output steering: zero-latency mux in PASS, synthetic bad beat in ABORT,
    // owner-only sink in DRAIN
    always_comb begin
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = '0;
        s_axis_tready = '0;
        case (r_state)
            PASS: begin
                m_axis_tvalid        = w_src_valid;
                m_axis_tdata         = s_axis_tdata[r_ptr*8 +: 8];
                m_axis_tlast         = w_src_last;
                m_axis_tuser         = s_axis_tuser[r_ptr*USER_WIDTH +: USER_WIDTH];
                s_axis_tready[r_ptr] = m_axis_tready;
            end
`ifdef TX_ARB_TIMEOUT_EN
            ABORT: begin
                // All-ones tuser sets the bad-frame flag so the FIFO drops it
                m_axis_tvalid = 1'b1;
                m_axis_tlast  = 1'b1;
                m_axis_tuser  = {USER_WIDTH{1'b1}};
            end
            DRAIN: begin
                s_axis_tready[r_ptr] = 1'b1;
            end
`endif
            default: begin
            end
        endcase
    end

endmodule
`default_nettype wire
